// File: rtl/prbs_checker.sv
// PRBS7 (x^7+x^6+1) receive checker with lock acquisition, lock-loss
// window, saturating error counter and seven-segment status display.
module prbs_checker #(
    parameter int LOCK_GOOD = 16,
    parameter int LOSS_ERRS = 4,
    parameter int LOSS_WIN  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       err_clr,
    output logic       locked,
    output logic [7:0] err_count,
    output logic [6:0] segments
);

    localparam int GW = $clog2(LOCK_GOOD + 1);
    localparam int WW = $clog2(LOSS_WIN + 1);
    localparam int EW = $clog2(LOSS_ERRS + 1);

    typedef enum logic [1:0] {
        SEED,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      sr_q, sr_d;
    logic [2:0]      seed_cnt_q, seed_cnt_d;
    logic [GW-1:0]   good_cnt_q, good_cnt_d;
    logic [WW-1:0]   win_bits_q, win_bits_d;
    logic [EW-1:0]   win_errs_q, win_errs_d;
    logic [7:0]      err_count_q, err_count_d;
    logic            locked_q, locked_d;

    logic            accept;
    logic            pred;
    logic            mism;
    logic [GW-1:0]   good_inc;
    logic [WW-1:0]   bits_inc;
    logic [EW-1:0]   errs_inc;
    logic [6:0]      glyph;

    assign accept   = ena & bit_valid;
    assign pred     = sr_q[6] ^ sr_q[5];
    assign mism     = bit_in ^ pred;
    assign good_inc = good_cnt_q + GW'(1);
    assign bits_inc = win_bits_q + WW'(1);
    assign errs_inc = win_errs_q + EW'(mism);

    // Next-state logic: seeding, acquisition, locked checking and err_clr.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        seed_cnt_d  = seed_cnt_q;
        good_cnt_d  = good_cnt_q;
        win_bits_d  = win_bits_q;
        win_errs_d  = win_errs_q;
        err_count_d = err_count_q;
        locked_d    = locked_q;
        if (accept) begin
            unique case (state_q)
                SEED: begin
                    sr_d = {sr_q[5:0], bit_in};
                    if (seed_cnt_q == 3'd6) begin
                        state_d    = ACQUIRE;
                        seed_cnt_d = 3'd0;
                        good_cnt_d = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 3'd1;
                    end
                end
                ACQUIRE: begin
                    sr_d = {sr_q[5:0], bit_in};
                    if (mism) begin
                        state_d    = SEED;
                        seed_cnt_d = 3'd0;
                        good_cnt_d = '0;
                    end else if (good_inc == GW'(LOCK_GOOD)) begin
                        state_d    = LOCKED;
                        locked_d   = 1'b1;
                        good_cnt_d = '0;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        good_cnt_d = good_inc;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so one bad bit is one error.
                    sr_d = {sr_q[5:0], pred};
                    if (mism && err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    if (errs_inc == EW'(LOSS_ERRS)) begin
                        state_d    = SEED;
                        locked_d   = 1'b0;
                        seed_cnt_d = 3'd0;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else if (bits_inc == WW'(LOSS_WIN)) begin
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        win_bits_d = bits_inc;
                        win_errs_d = errs_inc;
                    end
                end
                default: begin
                    state_d  = SEED;
                    locked_d = 1'b0;
                end
            endcase
        end
        if (ena && err_clr) begin
            err_count_d = 8'd0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SEED;
            sr_q        <= 7'd0;
            seed_cnt_q  <= 3'd0;
            good_cnt_q  <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
            err_count_q <= 8'd0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            seed_cnt_q  <= seed_cnt_d;
            good_cnt_q  <= good_cnt_d;
            win_bits_q  <= win_bits_d;
            win_errs_q  <= win_errs_d;
            err_count_q <= err_count_d;
            locked_q    <= locked_d;
        end
    end

    // Hex glyph of the low error-count nibble, {g,f,e,d,c,b,a}.
    always_comb begin
        glyph = 7'b0111111;
        unique case (err_count_q[3:0])
            4'h0: glyph = 7'b0111111;
            4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;
            4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;
            4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;
            4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1101111;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;
            4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;
            4'hF: glyph = 7'b1110001;
            default: glyph = 7'b0111111;
        endcase
    end

    assign locked    = locked_q;
    assign err_count = err_count_q;
    assign segments  = locked_q ? glyph : 7'b1000000;

endmodule
